// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan-bus decoder: dwell-filters each multiplexed digit and maps it back to hex.
// Optional SSD_ERR_COUNT_EN adds a saturating 8-bit err_count output.
module ssd_scan_decoder #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg,
   input  logic [NUM_DIGITS-1:0]   an,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    cap,
   output logic                    frame_done,
   output logic                    err,
   output logic                    err_sticky
`ifdef SSD_ERR_COUNT_EN
   ,
   output logic [7:0]              err_count
`endif
);

   localparam int unsigned SW = NUM_DIGITS + 7;
   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] BLANK = {{NUM_DIGITS{1'b1}}, 7'd0};
   localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   // Inverse of the encoder table; bit 4 of the result flags a recognised pattern.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b1111110: r = {1'b1, 4'h0};
         7'b0110000: r = {1'b1, 4'h1};
         7'b1101101: r = {1'b1, 4'h2};
         7'b1111001: r = {1'b1, 4'h3};
         7'b0110011: r = {1'b1, 4'h4};
         7'b1011011: r = {1'b1, 4'h5};
         7'b1011111: r = {1'b1, 4'h6};
         7'b1110000: r = {1'b1, 4'h7};
         7'b1111111: r = {1'b1, 4'h8};
         7'b1110011: r = {1'b1, 4'h9};
         7'b1110111: r = {1'b1, 4'hA};
         7'b0011111: r = {1'b1, 4'hB};
         7'b1001110: r = {1'b1, 4'hC};
         7'b0111101: r = {1'b1, 4'hD};
         7'b1001111: r = {1'b1, 4'hE};
         7'b1000111: r = {1'b1, 4'hF};
         default:    r = 5'd0;
      endcase
      return r;
   endfunction

   logic [SW-1:0]         sync_1;
   logic [SW-1:0]         sample;
   logic [SW-1:0]         prev_sample;
   logic [NUM_DIGITS-1:0] seen;
   logic [CW-1:0]         count;
   state_t                state;

   logic [NUM_DIGITS-1:0] an_n;
   logic                  an_onehot;
   logic                  an_illegal;
   logic                  changed;
   logic [4:0]            dec;
   logic [NUM_DIGITS-1:0] seen_upd;
   logic                  capture;
   logic                  anode_err;
   logic                  err_next;
   logic                  reeval;
   state_t                state_d;
   logic [CW-1:0]         count_d;

   always_comb begin
      an_n       = ~sample[SW-1:7];
      an_onehot  = (an_n != '0) && ((an_n & (an_n - DIG_ONE)) == '0);
      an_illegal = !an_onehot && (an_n != '0);
      changed    = sample != prev_sample;
      dec        = decode(sample[6:0]);
      seen_upd   = seen | an_n;
   end

   // Next-state: a change from TRACK or HOLD is handled exactly like a fresh look from IDLE.
   always_comb begin
      state_d   = state;
      count_d   = count;
      capture   = 1'b0;
      anode_err = 1'b0;
      reeval    = 1'b0;
      case (state)
         TRACK: begin
            if (changed) begin
               reeval = 1'b1;
            end else begin
               if (count != CNT_MAX) begin
                  count_d = count + CNT_ONE;
               end
               if (count_d == CNT_MAX) begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (changed) begin
               reeval = 1'b1;
            end
         end
         default: reeval = 1'b1;
      endcase
      if (reeval) begin
         if (an_onehot) begin
            state_d = TRACK;
            count_d = CNT_ONE;
         end else begin
            state_d = IDLE;
            count_d = '0;
            // Only a change into an illegal anode state reports, so a held fault pulses once.
            anode_err = an_illegal && changed;
         end
      end
      err_next = anode_err || (capture && !dec[4]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1      <= BLANK;
         sample      <= BLANK;
         prev_sample <= BLANK;
         state       <= IDLE;
         count       <= '0;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         cap         <= 1'b0;
         frame_done  <= 1'b0;
         err         <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         sync_1      <= {an, seg};
         sample      <= sync_1;
         prev_sample <= sample;
         state       <= state_d;
         count       <= count_d;
         cap         <= 1'b0;
         frame_done  <= 1'b0;
         err         <= err_next;
         if (err_next) begin
            err_sticky <= 1'b1;
         end
         if (capture && dec[4]) begin
            cap <= 1'b1;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
               if (an_n[i]) begin
                  digits[4*i +: 4] <= dec[3:0];
                  digit_valid[i]   <= 1'b1;
               end
            end
            if (seen_upd == '1) begin
               frame_done <= 1'b1;
               seen       <= '0;
            end else begin
               seen <= seen_upd;
            end
         end
      end
   end

`ifdef SSD_ERR_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= 8'd0;
      end else if (err_next && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed cases plus random scan traffic, checked each cycle
// against a run-length reference model of the sampled bus.
module tb_ssd_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    seg;
   logic [ND-1:0] an;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] digit_valid;
   logic          cap, frame_done, err, err_sticky;
`ifdef SSD_ERR_COUNT_EN
   logic [7:0]    err_count;
`endif

   ssd_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
      .digits      (digits),
      .digit_valid (digit_valid),
      .cap         (cap),
      .frame_done  (frame_done),
      .err         (err),
      .err_sticky  (err_sticky)
`ifdef SSD_ERR_COUNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cap_seen, fd_seen, err_seen;

   logic [6:0]  pats [16];
   logic [10:0] d1, d2, m_prev;
   int          run;
   logic [15:0] m_digits;
   logic [3:0]  m_valid, m_seen;
   logic        m_cap, m_fd, m_err, m_sticky;
   int          m_errcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      d1 = {4'hF, 7'd0}; d2 = d1; m_prev = d1; run = 1;
      m_digits = '0; m_valid = '0; m_seen = '0;
      m_cap = 0; m_fd = 0; m_err = 0; m_sticky = 0; m_errcnt = 0;
   endtask

   // The decoder sees, at each edge, the bus value present two edges earlier.
   task automatic m_edge();
      logic [10:0] s;
      int zeros, pos;
      logic found;
      logic [3:0] val;
      s = d2; d2 = d1; d1 = {an, seg};
      m_cap = 0; m_fd = 0; m_err = 0;
      if (s != m_prev) run = 1;
      else if (run < 1000000) run++;
      m_prev = s;
      zeros = 0; pos = 0;
      for (int i = 0; i < ND; i++) if (!s[7+i]) begin zeros++; pos = i; end
      if (zeros > 1 && run == 1) m_err = 1;
      if (zeros == 1 && run == SC) begin
         found = 0; val = 0;
         for (int v = 0; v < 16; v++) if (pats[v] == s[6:0]) begin found = 1; val = 4'(v); end
         if (found) begin
            m_digits[4*pos +: 4] = val;
            m_valid[pos] = 1; m_seen[pos] = 1; m_cap = 1;
            if (m_seen == 4'hF) begin m_fd = 1; m_seen = 0; end
         end else begin
            m_err = 1;
         end
      end
      if (m_err) begin
         m_sticky = 1;
         if (m_errcnt < 255) m_errcnt++;
      end
   endtask

   task automatic check_all();
      chk("cap", 32'(cap), 32'(m_cap));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("err", 32'(err), 32'(m_err));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("digits", 32'(digits), 32'(m_digits));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
`ifdef SSD_ERR_COUNT_EN
      chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
      if (cap === 1'b1) cap_seen++;
      if (frame_done === 1'b1) fd_seen++;
      if (err === 1'b1) err_seen++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) m_reset(); else m_edge();
      #1;
      check_all();
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] p, input int n);
      an = a; seg = p;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_reset();
      check_all();
      tick();
      rst = 1'b0;
      cap_seen = 0; fd_seen = 0; err_seen = 0;
   endtask

   initial begin
      logic [3:0] a;
      logic [6:0] p;
      int kind;
      pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
               7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      rst = 1'b1; an = 4'hF; seg = 7'd0;
      m_reset();
      #1 check_all();
      tick();
      rst = 1'b0;
      cap_seen = 0; fd_seen = 0; err_seen = 0;

      // Single digit 5 on digit 0.
      hold(4'b1110, pats[5], 10);
      chk("c1_caps", 32'(cap_seen), 32'd1);
      chk("c1_digits", 32'(digits), 32'h0005);
      chk("c1_valid", 32'(digit_valid), 32'b0001);
      chk("c1_err", 32'(err_seen), 32'd0);

      // Segment change mid-dwell restarts the dwell.
      do_reset();
      hold(4'b1110, pats[5], 3);
      hold(4'b1110, pats[3], 6);
      hold(4'hF, 7'd0, 3);
      chk("c2_caps", 32'(cap_seen), 32'd1);
      chk("c2_digit0", 32'(digits[3:0]), 32'd3);

      // Full scan 1,2,3,4.
      do_reset();
      for (int d = 0; d < 4; d++) begin
         a = ~(4'b0001 << d);
         hold(a, pats[d+1], 6);
         hold(4'hF, 7'd0, 2);
      end
      chk("c3_digits", 32'(digits), 32'h4321);
      chk("c3_valid", 32'(digit_valid), 32'hF);
      chk("c3_caps", 32'(cap_seen), 32'd4);
      chk("c3_frames", 32'(fd_seen), 32'd1);

      // Illegal segment pattern.
      do_reset();
      hold(4'b1110, 7'b0000101, 6);
      hold(4'hF, 7'd0, 3);
      chk("c4_sticky", 32'(err_sticky), 32'd1);
      chk("c4_digits", 32'(digits), 32'd0);
      chk("c4_errs", 32'(err_seen), 32'd1);
      chk("c4_caps", 32'(cap_seen), 32'd0);

      // Illegal anode state.
      do_reset();
      hold(4'b1100, 7'd0, 5);
      hold(4'hF, 7'd0, 3);
      chk("c5_errs", 32'(err_seen), 32'd1);
      chk("c5_caps", 32'(cap_seen), 32'd0);

      // Reset at count=3, then a clean dwell.
      do_reset();
      hold(4'b1110, pats[7], 5);
      do_reset();
      chk("c6_rst_digits", 32'(digits), 32'd0);
      chk("c6_rst_valid", 32'(digit_valid), 32'd0);
      hold(4'b1110, pats[7], 6);
      hold(4'hF, 7'd0, 3);
      chk("c6_caps", 32'(cap_seen), 32'd1);
      chk("c6_digits", 32'(digits), 32'h0007);

      // Random scan traffic.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         a = ~(4'b0001 << $urandom_range(0, 3));
         p = pats[$urandom_range(0, 15)];
         if (kind == 7) begin
            p = 7'($urandom);
            for (int v = 0; v < 16; v++) if (pats[v] == p) p = 7'b0000000;
         end else if (kind == 8) begin
            a = 4'($urandom_range(0, 15));
            if (a == 4'hF || a == 4'b1110 || a == 4'b1101 || a == 4'b1011 || a == 4'b0111)
               a = 4'b0101;
         end else if (kind == 9) begin
            a = 4'hF;
         end
         hold(a, p, int'($urandom_range(1, 8)));
      end
      hold(4'hF, 7'd0, 4);

`ifdef SSD_ERR_COUNT_EN
      do_reset();
      for (int n = 0; n < 300; n++) hold((n % 2 == 0) ? 4'b1100 : 4'b1010, 7'd0, 1);
      hold(4'hF, 7'd0, 4);
      chk("errcnt_sat", 32'(err_count), 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
